// File: rtl/wave_display_ctrl.sv
// ============================================================================
// Module   : wave_display_ctrl
// Brief    : Display-side sequencer for the double-buffered 512x8 sample RAM.
//            Maps VGA pixel coordinates to RAM read addresses in the locked
//            buffer half, absorbs the RAM read latency and draws connected
//            vertical segments between adjacent samples.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wave_display_ctrl #(
    parameter logic [10:0] X_LO   = 11'd64,
    parameter logic [9:0]  Y_ROWS = 10'd512,
    parameter logic [23:0] COLOR  = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    // One past the last window column, widened so the sum cannot wrap.
    localparam logic [11:0] X_HI = {1'b0, X_LO} + 12'd512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        lock_index;
    logic        lock_next;
    logic        drain_cnt;

    logic        wave_row;
    logic        in_win;
    logic [8:0]  xr;
    logic [7:0]  sample;

    logic        s1_win;
    logic [7:0]  s1_row;
    logic        s1_first;
    logic        s1_new;

    logic [7:0]  prev_value;
    logic [7:0]  hold_p;
    logic [7:0]  cur;
    logic [7:0]  p;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        lit;

    // Stage 0: window decode. Low 9 bits of the subtraction are exact inside the window.
    always_comb begin
        wave_row = (y < Y_ROWS);
        in_win   = valid && ({1'b0, x} >= {1'b0, X_LO}) && ({1'b0, x} < X_HI) && wave_row;
        xr       = x[8:0] - X_LO[8:0];
        sample   = xr[8:1];
    end

    // Frame sequencer: lock the buffer half at frame start, release after the pipeline drains.
    always_comb begin
        next_state = state;
        lock_next  = lock_index;
        case (state)
            IDLE: begin
                if (valid && wave_row) begin
                    next_state = DRAW;
                    lock_next  = read_index;
                end
            end
            DRAW: begin
                if (valid && !wave_row) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sequencer state, locked half, drain timer and swap-safe flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            lock_index        <= 1'b0;
            drain_cnt         <= 1'b0;
            wave_display_idle <= 1'b1;
        end else begin
            state             <= next_state;
            lock_index        <= lock_next;
            drain_cnt         <= (state == DRAIN) && !drain_cnt;
            wave_display_idle <= (next_state == IDLE);
        end
    end

    // Stage 0 -> 1: issue the RAM address (bypassing a freshly latched half) and carry pixel info.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_address <= 9'd0;
            s1_win       <= 1'b0;
            s1_row       <= 8'd0;
            s1_first     <= 1'b0;
            s1_new       <= 1'b0;
        end else begin
            if (in_win) begin
                read_address <= {lock_next, sample};
            end
            s1_win   <= in_win;
            s1_row   <= ~y[8:1];
            s1_first <= (xr == 9'd0);
            s1_new   <= ~xr[0];
        end
    end

    // Stage 1: pick the segment start. Both pixels of a sample share the segment chosen on the first.
    always_comb begin
        cur = read_value;
        if (s1_new) begin
            p = s1_first ? cur : prev_value;
        end else begin
            p = hold_p;
        end
        lo  = (p < cur) ? p : cur;
        hi  = (p < cur) ? cur : p;
        lit = (s1_row >= lo) && (s1_row <= hi);
    end

    // Remember the current sample and the segment start for the second pixel of this sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_value <= 8'd0;
            hold_p     <= 8'd0;
        end else if (s1_win && s1_new) begin
            prev_value <= cur;
            hold_p     <= p;
        end
    end

    // Stage 1 -> 2: registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pixel <= 1'b0;
            r           <= 8'd0;
            g           <= 8'd0;
            b           <= 8'd0;
        end else begin
            valid_pixel <= s1_win;
            if (s1_win && lit) begin
                {r, g, b} <= COLOR;
            end else begin
                {r, g, b} <= 24'h000000;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wave_display_ctrl.sv
// ============================================================================
// Module   : tb_wave_display_ctrl
// Brief    : Self-checking bench for wave_display_ctrl with a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wave_display_ctrl;

    localparam logic [10:0] X_LO  = 11'd64;
    localparam logic [23:0] COLOR = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        valid_pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        wave_display_idle;

    logic [7:0]  ram [0:511];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        cur_idx;
    logic [8:0]  exp_addr;

    typedef struct {
        int          t;
        logic [23:0] rgb;
    } exp_t;
    exp_t q[$];

    wave_display_ctrl #(.X_LO(X_LO), .Y_ROWS(10'd512), .COLOR(COLOR)) dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_value        (read_value),
        .read_address      (read_address),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .wave_display_idle (wave_display_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM behind a registered address: data for read_address is present in the following cycle.
    assign read_value = ram[read_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: segment between previous and current sample, inclusive, on row ~y[8:1].
    function automatic logic [23:0] exp_rgb(input logic idx, input int xr, input logic [9:0] yy);
        int k;
        logic [7:0] c;
        logic [7:0] pv;
        logic [7:0] row;
        logic [7:0] mn;
        logic [7:0] mx;
        k   = xr / 2;
        c   = ram[int'(idx) * 256 + k];
        pv  = (k == 0) ? c : ram[int'(idx) * 256 + k - 1];
        row = ~yy[8:1];
        mn  = (pv < c) ? pv : c;
        mx  = (pv < c) ? c : pv;
        return (row >= mn && row <= mx) ? COLOR : 24'h000000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [10:0] xx, input logic [9:0] yy);
        int xr;
        exp_t e;
        valid = v;
        x     = xx;
        y     = yy;
        xr    = int'(xx) - int'(X_LO);
        if (v && yy < 10'd512 && xr >= 0 && xr < 512) begin
            e.t   = cyc + 2;
            e.rgb = exp_rgb(cur_idx, xr, yy);
            q.push_back(e);
            exp_addr = {cur_idx, 8'(xr / 2)};
        end
        step();
        chk("read_address", 32'(read_address), 32'(exp_addr));
    endtask

    task automatic scan_row(input logic [9:0] yy);
        for (int xx = int'(X_LO) - 2; xx <= int'(X_LO) + 513; xx++) begin
            drive(1'b1, 11'(xx), yy);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 11'd0, yy);
        chk("idle_in_draw", 32'(wave_display_idle), 32'd0);
    endtask

    task automatic end_frame();
        drive(1'b1, 11'd10, 10'd520);
        chk("idle_drain", 32'(wave_display_idle), 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 11'd0, 10'd520);
        chk("idle_after_drain", 32'(wave_display_idle), 32'd1);
    endtask

    // Monitor: pop the expected pixel whenever the DUT presents one; blank outputs must be black.
    always @(negedge clk) begin
        if (valid_pixel) begin
            if (q.size() == 0) begin
                chk("unexpected_pixel", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pixel_time", 32'(cyc), 32'(e.t));
                chk("pixel_rgb", 32'({r, g, b}), 32'(e.rgb));
            end
        end else begin
            chk("blank_rgb", 32'({r, g, b}), 32'd0);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'd128;
        for (int i = 0; i < 256; i++) ram[256 + i] = 8'(i);
        reset      = 1'b1;
        valid      = 1'b0;
        x          = X_LO;
        y          = 10'd254;
        read_index = 1'b0;
        cur_idx    = 1'b0;
        exp_addr   = 9'd0;

        // Reset held with valid toggling.
        for (int i = 0; i < 3; i++) begin
            valid = i[0];
            step();
            chk("rst_valid_pixel", 32'(valid_pixel), 32'd0);
            chk("rst_rgb", 32'({r, g, b}), 32'd0);
            chk("rst_read_address", 32'(read_address), 32'd0);
            chk("rst_idle", 32'(wave_display_idle), 32'd1);
        end
        reset = 1'b0;
        valid = 1'b0;
        step();
        chk("idle_after_reset", 32'(wave_display_idle), 32'd1);

        // Frame A: flat 128 in half 0.
        read_index = 1'b0;
        cur_idx    = 1'b0;
        scan_row(10'd254);
        scan_row(10'd250);
        end_frame();

        // Frame B: ramp in half 1; toggling read_index mid-frame must not move the lock.
        read_index = 1'b1;
        cur_idx    = 1'b1;
        scan_row(10'd511);
        read_index = 1'b0;
        scan_row(10'd100);
        chk("lock_held", 32'(read_address[8]), 32'd1);
        scan_row(10'd200);
        end_frame();

        // Frame C: step 20 -> 200 at samples 10/11 in half 0; new index picked up.
        ram[10] = 8'd20;
        ram[11] = 8'd200;
        cur_idx = 1'b0;
        scan_row(10'd470);
        chk("new_lock", 32'(read_address[8]), 32'd0);
        scan_row(10'd310);
        scan_row(10'd110);
        scan_row(10'd108);
        end_frame();

        for (int i = 0; i < 4; i++) step();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
